// File: rtl/vga_pos_fetch_if.sv
// vga_pos_fetch_if: memory read port between the position fetcher and the memory arbiter
interface vga_pos_fetch_if;
   logic        mem_req;
   logic [15:0] mem_addr;
   logic        mem_gnt;
   logic        mem_rvalid;
   logic [15:0] mem_rdata;
   modport master (output mem_req, mem_addr, input mem_gnt, mem_rvalid, mem_rdata);
   modport slave (input mem_req, mem_addr, output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/vga_pos_fetch.sv
// vga_pos_fetch: reads six sprite coordinates per frame on v_sync fall and commits them atomically
module vga_pos_fetch #(
   parameter int unsigned MX      = 6000,
   parameter int unsigned MY      = 6004,
   parameter int unsigned P1X     = 6008,
   parameter int unsigned P1Y     = 6012,
   parameter int unsigned P2X     = 6016,
   parameter int unsigned P2Y     = 6020,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic            clk_50MHz,
   input  logic            clear,
   input  logic            v_sync,
   vga_pos_fetch_if.master mem,
   output logic [15:0]     mx,
   output logic [15:0]     my,
   output logic [15:0]     p1x,
   output logic [15:0]     p1y,
   output logic [15:0]     p2x,
   output logic [15:0]     p2y,
   output logic            frame_done,
   output logic            fetch_err
);
   localparam int CW = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, COMMIT} state_t;

   state_t        state, state_nx;
   logic          vs_q, vs_fall, last;
   logic          capture, commit, timeout;
   logic [2:0]    idx, idx_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [15:0]   addr;
   logic [15:0]   shadow [6];

   assign vs_fall = vs_q & ~v_sync;
   assign last    = idx == 3'd5;
   assign addr    = idx == 3'd0 ? 16'(MX)  :
                    idx == 3'd1 ? 16'(MY)  :
                    idx == 3'd2 ? 16'(P1X) :
                    idx == 3'd3 ? 16'(P1Y) :
                    idx == 3'd4 ? 16'(P2X) : 16'(P2Y);

   // state register; a reset always lands in IDLE so a fresh v_sync edge is needed
   always_ff @(posedge clk_50MHz) state <= !clear ? IDLE : state_nx;

   // next state, bus outputs and datapath strobes
   always_comb begin
      state_nx     = state;
      idx_nx       = idx;
      cnt_nx       = cnt;
      mem.mem_req  = 1'b0;
      mem.mem_addr = '0;
      capture      = 1'b0;
      commit       = 1'b0;
      timeout      = 1'b0;
      case (state)
         IDLE: if (vs_fall) begin
            state_nx = REQ;
            idx_nx   = '0;
         end
         REQ: begin
            mem.mem_req  = 1'b1;
            mem.mem_addr = addr;
            if (mem.mem_gnt) begin
               cnt_nx   = '0;
               state_nx = WAIT;
            end
         end
         WAIT: if (mem.mem_rvalid) begin
            capture  = 1'b1;
            state_nx = last ? COMMIT : REQ;
            idx_nx   = last ? idx : idx + 3'd1;
         end else if (cnt == CNT_LAST) begin
            timeout  = 1'b1;
            state_nx = IDLE;
         end else begin
            cnt_nx = cnt + 1'b1;
         end
         COMMIT: begin
            commit   = 1'b1;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // edge history, word index, timeout counter, shadow capture and atomic commit
   always_ff @(posedge clk_50MHz) begin
      if (!clear) begin
         vs_q       <= 1'b1;
         idx        <= '0;
         cnt        <= '0;
         shadow     <= '{default: '0};
         mx         <= '0;
         my         <= '0;
         p1x        <= '0;
         p1y        <= '0;
         p2x        <= '0;
         p2y        <= '0;
         frame_done <= 1'b0;
         fetch_err  <= 1'b0;
      end else begin
         vs_q       <= v_sync;
         idx        <= idx_nx;
         cnt        <= cnt_nx;
         if (capture) shadow[idx] <= mem.mem_rdata;
         if (commit) {mx, my, p1x, p1y, p2x, p2y} <= {shadow[0], shadow[1], shadow[2], shadow[3], shadow[4], shadow[5]};
         frame_done <= commit;
         fetch_err  <= fetch_err | timeout;
      end
   end
endmodule

// File: tb/tb_vga_pos_fetch.sv
// tb_vga_pos_fetch: randomized memory responder with a transaction-level reference model
module tb_vga_pos_fetch;
   localparam int TIMEOUT = 255;

   logic clk_50MHz = 1'b0;
   logic clear = 1'b0;
   logic v_sync = 1'b1;
   logic [15:0] mx, my, p1x, p1y, p2x, p2y;
   logic frame_done, fetch_err;

   vga_pos_fetch_if m ();

   vga_pos_fetch dut (
      .clk_50MHz(clk_50MHz), .clear(clear), .v_sync(v_sync), .mem(m),
      .mx(mx), .my(my), .p1x(p1x), .p1y(p1y), .p2x(p2x), .p2y(p2y),
      .frame_done(frame_done), .fetch_err(fetch_err)
   );

   always #10 clk_50MHz = ~clk_50MHz;

   int checks = 0, passed = 0;

   // reference model: fetch in progress, word being fetched, whether it was granted
   bit          busy, granted, exfd, exerr, prev_vs = 1'b1;
   int          w, waited;
   logic [15:0] sh [6];
   logic [15:0] ex [6];

   // memory responder
   logic [15:0] memv [6];
   int          fixed_dly [6];
   bit          rnd_gnt, spur, pend;
   int          age, dly, pidx, stall_left, stall_obs, words_rd, fd_cnt;
   logic [15:0] gq [$];

   task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
      checks++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   function automatic logic [95:0] coords();
      return {mx, my, p1x, p1y, p2x, p2y};
   endfunction

   task automatic model_step();
      if (!clear) begin
         busy = 0; granted = 0; w = 0; waited = 0; exfd = 0; exerr = 0; prev_vs = 1;
         for (int i = 0; i < 6; i++) begin sh[i] = '0; ex[i] = '0; end
      end else begin
         bit fall;
         fall = prev_vs && !v_sync;
         prev_vs = v_sync;
         exfd = 0;
         if (!busy) begin
            if (fall) begin busy = 1; w = 0; granted = 0; end
         end else if (w == 6) begin
            for (int i = 0; i < 6; i++) ex[i] = sh[i];
            exfd = 1; busy = 0;
         end else if (!granted) begin
            if (m.mem_gnt) begin granted = 1; waited = 0; end
         end else if (m.mem_rvalid) begin
            sh[w] = m.mem_rdata; w++; granted = 0;
         end else if (waited == TIMEOUT - 1) begin
            exerr = 1; busy = 0;
         end else waited++;
      end
   endtask

   task automatic compare();
      bit exp_req;
      exp_req = busy && !granted && w < 6;
      chk("mem_req", m.mem_req, exp_req);
      chk("mem_addr", m.mem_addr, exp_req ? 16'(6000 + 4 * w) : 16'd0);
      chk("frame_done", frame_done, exfd);
      chk("fetch_err", fetch_err, exerr);
      chk("coords", coords(), {ex[0], ex[1], ex[2], ex[3], ex[4], ex[5]});
      if (frame_done) fd_cnt++;
      if (m.mem_req && m.mem_addr == 16'd6008) stall_obs++;
   endtask

   task automatic respond();
      bit was_pend;
      was_pend = pend;
      m.mem_gnt = 0; m.mem_rvalid = 0; m.mem_rdata = 16'($urandom);
      if (pend) begin
         age++;
         if (age == dly) begin
            m.mem_rvalid = 1; m.mem_rdata = memv[pidx]; pend = 0; words_rd++;
         end else if (dly == 0 && age > TIMEOUT + 20) pend = 0;
      end else if (m.mem_req) begin
         if (m.mem_addr == 16'd6008 && stall_left > 0) stall_left--;
         else if (!rnd_gnt || $urandom_range(0, 2) != 0) begin
            m.mem_gnt = 1; pend = 1; age = 0;
            pidx = (int'(m.mem_addr) - 6000) / 4;
            if (pidx < 0 || pidx > 5) pidx = 0;
            gq.push_back(m.mem_addr);
            if (fixed_dly[pidx] >= 0) dly = fixed_dly[pidx];
            else dly = ($urandom_range(0, 29) == 0) ? 0 : $urandom_range(1, 4);
         end
      end
      if (spur && !was_pend && !m.mem_rvalid && $urandom_range(0, 7) == 0) m.mem_rvalid = 1;
      if (spur && !m.mem_req && $urandom_range(0, 7) == 0) m.mem_gnt = 1;
   endtask

   task automatic tick();
      model_step();
      @(posedge clk_50MHz);
      @(negedge clk_50MHz);
      compare();
      respond();
   endtask

   task automatic run_fd(input int lim, output int n);
      n = 0;
      do begin tick(); n++; end while (!frame_done && n < lim);
      chk("fd_within_bound", frame_done, 1'b1);
   endtask

   task automatic set_mem(input int base);
      for (int i = 0; i < 6; i++) begin memv[i] = 16'(base + i); fixed_dly[i] = 1; end
   endtask

   task automatic new_edge();
      v_sync = 1; tick(); v_sync = 0;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

   initial begin
      int n, fd0, g0, vph, vper;
      m.mem_gnt = 0; m.mem_rvalid = 0; m.mem_rdata = 0;
      pend = 0; rnd_gnt = 0; spur = 0; stall_left = 0; fd_cnt = 0; words_rd = 0;
      set_mem(0);
      clear = 0;
      repeat (3) tick();
      chk("rst_coords", coords(), 96'd0);
      chk("rst_err", fetch_err, 1'b0);
      chk("rst_req", {m.mem_req, m.mem_addr}, 17'd0);
      clear = 1;
      repeat (3) tick();

      // nominal frame
      for (int i = 0; i < 6; i++) begin memv[i] = 16'(10 * (i + 1)); fixed_dly[i] = 1; end
      gq.delete(); fd0 = fd_cnt;
      new_edge();
      run_fd(100, n);
      chk("nominal_latency", n, 14);
      chk("nominal_coords", coords(), {16'd10, 16'd20, 16'd30, 16'd40, 16'd50, 16'd60});
      chk("nominal_ngrants", gq.size(), 6);
      for (int i = 0; i < 6 && i < gq.size(); i++) chk("nominal_addr_order", gq[i], 16'(6000 + 4 * i));
      v_sync = 1;
      repeat (5) tick();
      chk("nominal_one_pulse", fd_cnt - fd0, 1);
      chk("nominal_err", fetch_err, 1'b0);

      // grant stall on the P1X read
      set_mem(101); stall_left = 5; stall_obs = 0;
      new_edge();
      run_fd(100, n);
      chk("stall_latency", n, 19);
      chk("stall_p1x_req_cycles", stall_obs, 6);
      chk("stall_coords", coords(), {16'd101, 16'd102, 16'd103, 16'd104, 16'd105, 16'd106});

      // data in the last permitted wait cycle is still accepted
      set_mem(111); fixed_dly[2] = 255;
      new_edge();
      run_fd(400, n);
      chk("late_rvalid_latency", n, 268);
      chk("late_rvalid_err", fetch_err, 1'b0);
      chk("late_rvalid_coords", coords(), {16'd111, 16'd112, 16'd113, 16'd114, 16'd115, 16'd116});

      // MY never answers -> timeout, previous frame kept
      set_mem(201); fixed_dly[1] = 0; fd0 = fd_cnt;
      new_edge();
      n = 0;
      do begin tick(); n++; end while (!fetch_err && n < 400);
      chk("timeout_latency", n, 259);
      repeat (30) tick();
      chk("timeout_keep_coords", coords(), {16'd111, 16'd112, 16'd113, 16'd114, 16'd115, 16'd116});
      chk("timeout_no_fd", fd_cnt - fd0, 0);
      set_mem(301);
      new_edge();
      run_fd(100, n);
      chk("recover_latency", n, 14);
      chk("recover_coords", coords(), {16'd301, 16'd302, 16'd303, 16'd304, 16'd305, 16'd306});
      chk("recover_err_sticky", fetch_err, 1'b1);

      // second edge while waiting for data is ignored
      set_mem(401); fd0 = fd_cnt;
      new_edge();
      tick(); v_sync = 1;
      repeat (3) tick();
      v_sync = 0;
      repeat (40) tick();
      chk("edge_in_fetch_one_commit", fd_cnt - fd0, 1);
      chk("edge_in_fetch_coords", coords(), {16'd401, 16'd402, 16'd403, 16'd404, 16'd405, 16'd406});

      // reset after three words
      set_mem(501); words_rd = 0; fd0 = fd_cnt;
      new_edge();
      tick(); v_sync = 1;
      n = 0;
      while (words_rd < 3 && n < 50) begin tick(); n++; end
      chk("rst_mid_words", words_rd, 3);
      clear = 0; pend = 0;
      tick();
      clear = 1;
      chk("rst_mid_coords", coords(), 96'd0);
      chk("rst_mid_err", fetch_err, 1'b0);
      g0 = gq.size();
      repeat (30) tick();
      chk("rst_mid_no_fd", fd_cnt - fd0, 0);
      chk("rst_mid_no_req", gq.size() - g0, 0);
      set_mem(601);
      new_edge();
      run_fd(100, n);
      chk("rst_mid_restart_latency", n, 14);
      chk("rst_mid_restart_coords", coords(), {16'd601, 16'd602, 16'd603, 16'd604, 16'd605, 16'd606});

      // spurious strobes while idle
      v_sync = 1; spur = 1; fd0 = fd_cnt; g0 = gq.size();
      repeat (40) tick();
      chk("spur_coords", coords(), {16'd601, 16'd602, 16'd603, 16'd604, 16'd605, 16'd606});
      chk("spur_no_fd", fd_cnt - fd0, 0);
      chk("spur_no_grant", gq.size() - g0, 0);

      // randomized traffic: random grants, delays, timeouts, spurious strobes, edges, resets
      rnd_gnt = 1;
      for (int i = 0; i < 6; i++) fixed_dly[i] = -1;
      vph = 0; vper = 20;
      for (int c = 0; c < 5000; c++) begin
         if (vph >= vper) begin vph = 0; vper = $urandom_range(8, 60); end
         v_sync = vph >= 3;
         vph++;
         clear = $urandom_range(0, 799) != 0;
         if (!clear) pend = 0;
         if (frame_done) for (int i = 0; i < 6; i++) memv[i] = 16'($urandom);
         tick();
      end
      clear = 1;
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
